// File: rtl/alu_seq_exec.sv
// Execute-stage ALU: single-cycle add/sub/and/or/slt, iterative one-bit-per-cycle sll,
// valid/ready handshake on both sides so the hazard unit can stall around long shifts.
module alu_seq_exec #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         alu_op,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               err
);

  localparam logic [2:0] OpAnd = 3'b000;
  localparam logic [2:0] OpOr  = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpSll = 3'b100;
  localparam logic [2:0] OpSub = 3'b110;
  localparam logic [2:0] OpSlt = 3'b111;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               err_q, err_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH-1:0]   shift_nxt;

  always_comb begin
    alu_res = '0;
    case (alu_op)
      OpAnd:   alu_res = src_a & src_b;
      OpOr:    alu_res = src_a | src_b;
      OpAdd:   alu_res = src_a + src_b;
      OpSub:   alu_res = src_a - src_b;
      OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: alu_res = '0;
    endcase
  end

  assign shift_nxt = shift_q << 1;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = err_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          err_d = 1'b0;
          case (alu_op)
            OpAnd, OpOr, OpAdd, OpSub, OpSlt: begin
              result_d = alu_res;
              zero_d   = (alu_res == '0);
              state_d  = StDone;
            end
            OpSll: begin
              shift_d = src_b;
              cnt_d   = shamt;
              if (shamt == '0) begin
                result_d = src_b;
                zero_d   = (src_b == '0);
                state_d  = StDone;
              end else begin
                state_d = StShift;
              end
            end
            default: begin
              result_d = '0;
              zero_d   = 1'b1;
              err_d    = 1'b1;
              state_d  = StDone;
            end
          endcase
        end
      end
      StShift: begin
        shift_d = shift_nxt;
        cnt_d   = cnt_q - 1'b1;
        // Counter at 1 means this cycle performs the last shift.
        if (cnt_q == SHAMT_W'(1)) begin
          result_d = shift_nxt;
          zero_d   = (shift_nxt == '0);
          state_d  = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      result_q <= '0;
      zero_q   <= 1'b1;
      err_q    <= 1'b0;
      shift_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign zero      = zero_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed bench for alu_seq_exec: vector table for op results/latency, plus
// hand-written backpressure and reset-during-shift sequences.
module tb_alu_seq_exec;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [4:0]  shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq_exec #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .src_a     (src_a),
    .src_b     (src_b),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .err       (err)
  );

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        z;
    logic        e;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one op (already in IDLE), waits for out_valid, captures outputs, then hands off.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, output int lat, output logic [31:0] r,
                       output logic z, output logic e, output logic busy_ok);
    in_valid = 1'b1;
    alu_op   = op;
    src_a    = a;
    src_b    = b;
    shamt    = sh;
    tick();
    in_valid = 1'b0;
    alu_op   = 3'b010;
    src_a    = ~a;
    src_b    = ~b;
    shamt    = ~sh;
    lat      = 1;
    busy_ok  = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_ok = 1'b0;
      tick();
      lat++;
    end
    if (in_ready) busy_ok = 1'b0;
    r = result;
    z = zero;
    e = err;
    tick();
  endtask

  initial begin
    int          lat;
    logic [31:0] r;
    logic        z;
    logic        e;
    logic        busy_ok;
    logic        saw_valid;

    vecs[0]  = '{"add",        3'b010, 32'h0000_0005, 32'h0000_0003, 5'd0,  32'h0000_0008, 1'b0, 1'b0, 1};
    vecs[1]  = '{"sub_neg",    3'b110, 32'h0000_0003, 32'h0000_0005, 5'd0,  32'hFFFF_FFFE, 1'b0, 1'b0, 1};
    vecs[2]  = '{"slt_true",   3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0001, 1'b0, 1'b0, 1};
    vecs[3]  = '{"slt_false",  3'b111, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0,  32'h0000_0000, 1'b1, 1'b0, 1};
    vecs[4]  = '{"undef_101",  3'b101, 32'h1111_1111, 32'h2222_2222, 5'd3,  32'h0000_0000, 1'b1, 1'b1, 1};
    vecs[5]  = '{"sub_eq",     3'b110, 32'h0000_1234, 32'h0000_1234, 5'd0,  32'h0000_0000, 1'b1, 1'b0, 1};
    vecs[6]  = '{"and",        3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'hF000_F000, 1'b0, 1'b0, 1};
    vecs[7]  = '{"or",         3'b001, 32'h0F0F_0000, 32'h0000_00FF, 5'd0,  32'h0F0F_00FF, 1'b0, 1'b0, 1};
    vecs[8]  = '{"add_wrap",   3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000, 1'b1, 1'b0, 1};
    vecs[9]  = '{"sll_4",      3'b100, 32'hDEAD_BEEF, 32'h0000_0001, 5'd4,  32'h0000_0010, 1'b0, 1'b0, 5};
    vecs[10] = '{"sll_0",      3'b100, 32'h0000_0000, 32'hA5A5_A5A5, 5'd0,  32'hA5A5_A5A5, 1'b0, 1'b0, 1};
    vecs[11] = '{"sll_31",     3'b100, 32'h0000_0000, 32'h0000_0003, 5'd31, 32'h8000_0000, 1'b0, 1'b0, 32};
    vecs[12] = '{"sll_out0",   3'b100, 32'h0000_0000, 32'h0000_0100, 5'd24, 32'h0000_0000, 1'b1, 1'b0, 25};

    rst       = 1'b1;
    in_valid  = 1'b0;
    alu_op    = 3'b000;
    src_a     = '0;
    src_b     = '0;
    shamt     = '0;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result",    result,         32'd0);
    check("rst_zero",      32'(zero),      32'd1);
    check("rst_err",       32'(err),       32'd0);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, lat, r, z, e, busy_ok);
      check({vecs[i].name, "_result"}, r,          vecs[i].res);
      check({vecs[i].name, "_zero"},   32'(z),     32'(vecs[i].z));
      check({vecs[i].name, "_err"},    32'(e),     32'(vecs[i].e));
      check({vecs[i].name, "_lat"},    32'(lat),   32'(vecs[i].lat));
      check({vecs[i].name, "_busy"},   32'(busy_ok), 32'd1);
      check({vecs[i].name, "_idle"},   32'(in_ready), 32'd1);
    end

    // Backpressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    alu_op    = 3'b000;
    src_a     = 32'hF0F0_F0F0;
    src_b     = 32'hFF00_FF00;
    tick();
    in_valid = 1'b0;
    src_a    = '0;
    check("bp_valid", 32'(out_valid), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_hold_result", result,          32'hF000_F000);
      check("bp_hold_valid",  32'(out_valid),  32'd1);
      check("bp_hold_ready",  32'(in_ready),   32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready),  32'd1);
    do_op(3'b011, 32'h5555_5555, 32'h0000_0001, 5'd0, lat, r, z, e, busy_ok);
    check("undef011_result", r,        32'd0);
    check("undef011_zero",   32'(z),   32'd1);
    check("undef011_err",    32'(e),   32'd1);
    check("undef011_lat",    32'(lat), 32'd1);

    // Reset during a long shift discards the pending result.
    in_valid = 1'b1;
    alu_op   = 3'b100;
    src_b    = 32'h0000_0001;
    shamt    = 5'd20;
    tick();
    in_valid = 1'b0;
    check("rs_busy", 32'(in_ready), 32'd0);
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rs_out_valid", 32'(out_valid), 32'd0);
    check("rs_in_ready",  32'(in_ready),  32'd1);
    check("rs_result",    result,         32'd0);
    check("rs_zero",      32'(zero),      32'd1);
    saw_valid = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (out_valid) saw_valid = 1'b1;
    end
    check("rs_no_pulse", 32'(saw_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
